// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the P8 fetch stage: F/D info bundle layout,
// exception codes and the default reset/handler/fetch-window addresses.
package fetch_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXC_W = 5;

  localparam logic [XLEN-1:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [XLEN-1:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [XLEN-1:0] IM_BASE_DEF    = 32'h0000_3000;
  localparam logic [XLEN-1:0] IM_LIMIT_DEF   = 32'h0000_6FFC;

  localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instr;
    logic [EXC_W-1:0] exccode;
    logic             bd;
    logic             valid;
  } info_t;

  localparam int unsigned INFO_W = $bits(info_t);

  // Misaligned or outside the instruction window.
  function automatic logic addr_fault(input logic [XLEN-1:0] addr,
                                      input logic [XLEN-1:0] base,
                                      input logic [XLEN-1:0] limit);
    return (addr[1:0] != 2'b00) || (addr < base) || (addr > limit);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Control and bus signals between the fetch stage and the rest of the core.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            stall;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            d_is_cti;
  logic            exc_req;
  logic            eret_req;
  logic [XLEN-1:0] epc;
  logic [XLEN-1:0] im_addr;
  logic [XLEN-1:0] im_rdata;
  info_t           info;

  modport master (
    input  stall, br_taken, br_target, d_is_cti, exc_req, eret_req, epc, im_rdata,
    output im_addr, info
  );

  modport slave (
    output stall, br_taken, br_target, d_is_cti, exc_req, eret_req, epc, im_rdata,
    input  im_addr, info
  );

endinterface

// File: rtl/fetch_stage_npc.sv
// Next-PC priority mux: exception > eret > stall hold > taken branch > sequential.
module fetch_npc
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] HANDLER_PC = HANDLER_PC_DEF
) (
  input  logic [XLEN-1:0] pc_q,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            exc_req,
  input  logic            eret_req,
  input  logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] npc_c
);

  always_comb begin
    npc_c = pc_q + XLEN'(4);
    if (exc_req)       npc_c = HANDLER_PC;
    else if (eret_req) npc_c = epc;
    else if (stall)    npc_c = pc_q;
    else if (br_taken) npc_c = br_target;
  end

endmodule

// File: rtl/fetch_stage.sv
// F stage and F/D pipeline register: PC, BRAM addressing, fetch address check
// and delay-slot tagging of the bundle handed to the D stage.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [XLEN-1:0] HANDLER_PC = HANDLER_PC_DEF,
  parameter logic [XLEN-1:0] IM_BASE    = IM_BASE_DEF,
  parameter logic [XLEN-1:0] IM_LIMIT   = IM_LIMIT_DEF
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] npc;
  logic            flush;
  logic            fault;
  info_t           info_d;

  fetch_npc #(.HANDLER_PC(HANDLER_PC)) u_npc (
    .pc_q      (pc_q),
    .stall     (bus.stall),
    .br_taken  (bus.br_taken),
    .br_target (bus.br_target),
    .exc_req   (bus.exc_req),
    .eret_req  (bus.eret_req),
    .epc       (bus.epc),
    .npc_c     (npc)
  );

  assign flush = bus.exc_req | bus.eret_req;
  assign fault = addr_fault(pc_q, IM_BASE, IM_LIMIT);

  // BRAM is read with the next PC so its data lines up with pc_q one edge later.
  assign bus.im_addr = reset ? RESET_PC : npc;

  // Next F/D contents: bubble on flush, hold on stall, else fetched word or AdEL nop.
  always_comb begin
    info_d = bus.info;
    if (flush) begin
      info_d    = '0;
      info_d.pc = pc_q;
    end else if (!bus.stall) begin
      info_d.pc      = pc_q;
      info_d.instr   = fault ? '0 : bus.im_rdata;
      info_d.exccode = fault ? EXC_ADEL : EXC_NONE;
      info_d.bd      = bus.d_is_cti;
      info_d.valid   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      bus.info <= '0;
    end else begin
      pc_q     <= npc;
      bus.info <= info_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scenario tasks drive per-cycle stimulus,
// a behavioural model pushes expectations to a scoreboard queue, tasks pop and compare.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  // Synchronous instruction BRAM: one-cycle read latency.
  always @(posedge clk) bus.im_rdata <= mem_word(bus.im_addr);

  typedef struct {
    logic        rst;
    logic        stl;
    logic        br;
    logic [31:0] tgt;
    logic        cti;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
  } stim_t;

  typedef struct {
    logic [31:0] addr;
    info_t       info;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_pc;
  info_t       m_info;
  logic [31:0] act_addr;
  info_t       act_info;

  function automatic stim_t mk(input logic rst, input logic stl, input logic br,
                               input logic [31:0] tgt, input logic cti,
                               input logic exc, input logic eret, input logic [31:0] epc);
    stim_t s;
    s.rst = rst; s.stl = stl; s.br = br; s.tgt = tgt;
    s.cti = cti; s.exc = exc; s.eret = eret; s.epc = epc;
    return s;
  endfunction

  // One cycle, starting at a falling edge: drive, predict, sample im_addr, clock, sample info.
  task automatic drive(input stim_t s);
    logic [31:0] npc;
    logic        bad;
    exp_t        e;
    reset         = s.rst;
    bus.stall     = s.stl;
    bus.br_taken  = s.br;
    bus.br_target = s.tgt;
    bus.d_is_cti  = s.cti;
    bus.exc_req   = s.exc;
    bus.eret_req  = s.eret;
    bus.epc       = s.epc;
    if (s.exc)       npc = 32'h0000_4180;
    else if (s.eret) npc = s.epc;
    else if (s.stl)  npc = m_pc;
    else if (s.br)   npc = s.tgt;
    else             npc = m_pc + 32'd4;
    if (s.rst) begin
      e.addr = 32'h0000_3000;
      m_info = '0;
      m_pc   = 32'h0000_3000;
    end else begin
      e.addr = npc;
      bad = (m_pc[1:0] != 2'b00) || (m_pc < 32'h0000_3000) || (m_pc > 32'h0000_6FFC);
      if (s.exc || s.eret) begin
        m_info    = '0;
        m_info.pc = m_pc;
      end else if (!s.stl) begin
        m_info.pc      = m_pc;
        m_info.instr   = bad ? 32'd0 : mem_word(m_pc);
        m_info.exccode = bad ? 5'd4 : 5'd0;
        m_info.bd      = s.cti;
        m_info.valid   = 1'b1;
      end
      m_pc = npc;
    end
    e.info = m_info;
    exp_q.push_back(e);
    #1 act_addr = bus.im_addr;
    @(posedge clk);
    #1 act_info = bus.info;
    @(negedge clk);
  endtask

  stim_t idle;

  task automatic test_reset();
    stim_t st[$];
    exp_t  e;
    repeat (3) st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) st.push_back(idle);
    foreach (st[i]) begin
      drive(st[i]);
      e = exp_q.pop_front();
      n_checks += 2;
      if (act_addr !== e.addr) begin n_fail++; $display("FAIL reset.im_addr[%0d] got %h exp %h", i, act_addr, e.addr); end
      if (act_info !== e.info) begin n_fail++; $display("FAIL reset.info[%0d] got %h exp %h", i, act_info, e.info); end
      if (i == 2) begin
        n_checks++;
        if (act_addr !== 32'h3000 || act_info !== info_t'(0)) begin
          n_fail++; $display("FAIL reset.state got addr %h info %h exp addr 3000 info 0", act_addr, act_info);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (act_info.pc !== 32'h3000 || act_info.valid !== 1'b1 || act_info.instr !== 32'hC0DE3000) begin
          n_fail++; $display("FAIL reset.first_fetch got pc %h valid %b instr %h exp 3000 1 c0de3000", act_info.pc, act_info.valid, act_info.instr);
        end
      end
    end
  endtask

  task automatic test_stall();
    stim_t st[$];
    exp_t  e;
    repeat (2) st.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    repeat (2) st.push_back(idle);
    foreach (st[i]) begin
      drive(st[i]);
      e = exp_q.pop_front();
      n_checks += 2;
      if (act_addr !== e.addr) begin n_fail++; $display("FAIL stall.im_addr[%0d] got %h exp %h", i, act_addr, e.addr); end
      if (act_info !== e.info) begin n_fail++; $display("FAIL stall.info[%0d] got %h exp %h", i, act_info, e.info); end
      if (i < 2) begin
        n_checks++;
        if (act_addr !== 32'h3008 || act_info.pc !== 32'h3004) begin
          n_fail++; $display("FAIL stall.hold got addr %h pc %h exp 3008 3004", act_addr, act_info.pc);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (act_info.pc !== 32'h300C) begin n_fail++; $display("FAIL stall.resume got pc %h exp 300c", act_info.pc); end
      end
    end
  endtask

  task automatic test_branch();
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(0, 0, 1, 32'h3040, 1, 0, 0, 0));
    repeat (2) st.push_back(idle);
    foreach (st[i]) begin
      drive(st[i]);
      e = exp_q.pop_front();
      n_checks += 2;
      if (act_addr !== e.addr) begin n_fail++; $display("FAIL branch.im_addr[%0d] got %h exp %h", i, act_addr, e.addr); end
      if (act_info !== e.info) begin n_fail++; $display("FAIL branch.info[%0d] got %h exp %h", i, act_info, e.info); end
      if (i == 0) begin
        n_checks++;
        if (act_info.pc !== 32'h3010 || act_info.bd !== 1'b1) begin
          n_fail++; $display("FAIL branch.delay_slot got pc %h bd %b exp 3010 1", act_info.pc, act_info.bd);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (act_info.pc !== 32'h3040 || act_info.bd !== 1'b0) begin
          n_fail++; $display("FAIL branch.target got pc %h bd %b exp 3040 0", act_info.pc, act_info.bd);
        end
      end
    end
  endtask

  task automatic test_exception();
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    repeat (8) st.push_back(idle);
    st.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0));
    st.push_back(mk(0, 0, 1, 32'h3100, 0, 1, 1, 32'h3500));
    st.push_back(idle);
    foreach (st[i]) begin
      drive(st[i]);
      e = exp_q.pop_front();
      n_checks += 2;
      if (act_addr !== e.addr) begin n_fail++; $display("FAIL exc.im_addr[%0d] got %h exp %h", i, act_addr, e.addr); end
      if (act_info !== e.info) begin n_fail++; $display("FAIL exc.info[%0d] got %h exp %h", i, act_info, e.info); end
      if (i == 9) begin
        n_checks++;
        if (act_addr !== 32'h4180 || act_info.valid !== 1'b0 || act_info.pc !== 32'h3020) begin
          n_fail++; $display("FAIL exc.bubble got addr %h valid %b pc %h exp 4180 0 3020", act_addr, act_info.valid, act_info.pc);
        end
      end
      if (i == 10) begin
        n_checks++;
        if (act_addr !== 32'h4180) begin n_fail++; $display("FAIL exc.over_eret got addr %h exp 4180", act_addr); end
      end
    end
  endtask

  task automatic test_eret();
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h3001));
    repeat (2) st.push_back(idle);
    st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h7000));
    st.push_back(idle);
    st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h6FFC));
    repeat (2) st.push_back(idle);
    st.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h2FFC));
    st.push_back(idle);
    foreach (st[i]) begin
      drive(st[i]);
      e = exp_q.pop_front();
      n_checks += 2;
      if (act_addr !== e.addr) begin n_fail++; $display("FAIL eret.im_addr[%0d] got %h exp %h", i, act_addr, e.addr); end
      if (act_info !== e.info) begin n_fail++; $display("FAIL eret.info[%0d] got %h exp %h", i, act_info, e.info); end
      if (i == 1 || i == 4 || i == 9) begin
        n_checks++;
        if (act_info.exccode !== 5'd4 || act_info.instr !== 32'd0 || act_info.valid !== 1'b1) begin
          n_fail++; $display("FAIL eret.adel[%0d] got exc %0d instr %h valid %b exp 4 0 1", i, act_info.exccode, act_info.instr, act_info.valid);
        end
      end
      if (i == 6) begin
        n_checks++;
        if (act_info.pc !== 32'h6FFC || act_info.exccode !== 5'd0 || act_info.instr !== 32'hC0DE6FFC) begin
          n_fail++; $display("FAIL eret.limit got pc %h exc %0d instr %h exp 6ffc 0 c0de6ffc", act_info.pc, act_info.exccode, act_info.instr);
        end
      end
    end
  endtask

  task automatic test_stall_branch_reset();
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    repeat (4) st.push_back(idle);
    st.push_back(mk(0, 1, 1, 32'h3040, 0, 0, 0, 0));
    st.push_back(mk(0, 0, 1, 32'h3040, 0, 0, 0, 0));
    st.push_back(idle);
    st.push_back(mk(1, 1, 1, 32'h3080, 0, 0, 0, 0));
    st.push_back(idle);
    foreach (st[i]) begin
      drive(st[i]);
      e = exp_q.pop_front();
      n_checks += 2;
      if (act_addr !== e.addr) begin n_fail++; $display("FAIL stlbr.im_addr[%0d] got %h exp %h", i, act_addr, e.addr); end
      if (act_info !== e.info) begin n_fail++; $display("FAIL stlbr.info[%0d] got %h exp %h", i, act_info, e.info); end
      if (i == 5) begin
        n_checks++;
        if (act_addr !== 32'h3010) begin n_fail++; $display("FAIL stlbr.br_ignored got addr %h exp 3010", act_addr); end
      end
      if (i == 7) begin
        n_checks++;
        if (act_info.pc !== 32'h3040) begin n_fail++; $display("FAIL stlbr.target got pc %h exp 3040", act_info.pc); end
      end
      if (i == 8) begin
        n_checks++;
        if (act_addr !== 32'h3000 || act_info !== info_t'(0)) begin
          n_fail++; $display("FAIL stlbr.reset got addr %h info %h exp 3000 0", act_addr, act_info);
        end
      end
    end
  endtask

  task automatic test_random();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 300; i++) begin
      s.rst  = ($urandom_range(0, 49) == 0);
      s.stl  = ($urandom_range(0, 3) == 0);
      s.br   = ($urandom_range(0, 3) == 0);
      s.tgt  = 32'h3000 + {18'd0, 12'($urandom_range(0, 32'hFFF)), 2'b00};
      s.cti  = 1'($urandom_range(0, 1));
      s.exc  = ($urandom_range(0, 19) == 0);
      s.eret = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       s.epc = 32'h3002;
        1:       s.epc = 32'h6FFC;
        default: s.epc = 32'h3000 + {18'd0, 12'($urandom_range(0, 32'hFFF)), 2'b00};
      endcase
      drive(s);
      e = exp_q.pop_front();
      n_checks += 2;
      if (act_addr !== e.addr) begin n_fail++; $display("FAIL rand.im_addr[%0d] got %h exp %h", i, act_addr, e.addr); end
      if (act_info !== e.info) begin n_fail++; $display("FAIL rand.info[%0d] got %h exp %h", i, act_info, e.info); end
    end
  endtask

  initial begin
    idle          = mk(0, 0, 0, 0, 0, 0, 0, 0);
    reset         = 1'b1;
    bus.stall     = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = '0;
    bus.d_is_cti  = 1'b0;
    bus.exc_req   = 1'b0;
    bus.eret_req  = 1'b0;
    bus.epc       = '0;
    @(negedge clk);
    test_reset();
    test_stall();
    test_branch();
    test_exception();
    test_eret();
    test_stall_branch_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
